// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its stream checker.
package fib_pkg;

  localparam int unsigned FIB_WIDTH = 16;
  localparam int unsigned FIB_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONE   = 2'd1,
    TRACK = 2'd2,
    FAIL  = 2'd3
  } fib_chk_state_t;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: next term = a + b, with the carry out of WIDTH bits.
module fib_step #(
  parameter int unsigned WIDTH = fib_pkg::FIB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_c,
  output logic             carry_c
);

  logic [WIDTH:0] w_sum;

  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign next_c  = w_sum[WIDTH-1:0];
  assign carry_c = w_sum[WIDTH];

endmodule

// File: rtl/fib_checker.sv
// Checks that a valid-qualified stream follows the Fibonacci recurrence mod 2^WIDTH;
// reports lock, term count, first mismatch and sum overflow.
module fib_checker
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH        = FIB_WIDTH,
  parameter int unsigned CNT_W        = FIB_CNT_W,
  parameter bit          STRICT_START = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [CNT_W-1:0] term_count,
  output logic             locked,
  output logic             mismatch,
  output logic             error,
  output logic [CNT_W-1:0] err_index,
  output logic             wrapped
);

  fib_chk_state_t   r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_term_count;
  logic             r_locked;
  logic             r_mismatch;
  logic             r_error;
  logic [CNT_W-1:0] r_err_index;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_expected;
  logic             w_carry;
  logic [CNT_W-1:0] w_count_inc;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a       (r_a),
    .b       (r_b),
    .next_c  (w_expected),
    .carry_c (w_carry)
  );

  // Counter sticks at all-ones; comparison keeps running past that point.
  assign w_count_inc = (r_term_count == {CNT_W{1'b1}}) ? r_term_count
                                                       : r_term_count + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_term_count <= '0;
      r_locked     <= 1'b0;
      r_mismatch   <= 1'b0;
      r_error      <= 1'b0;
      r_err_index  <= '0;
      r_wrapped    <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (clear) begin
        r_state      <= IDLE;
        r_a          <= '0;
        r_b          <= '0;
        r_term_count <= '0;
        r_locked     <= 1'b0;
        r_error      <= 1'b0;
        r_err_index  <= '0;
        r_wrapped    <= 1'b0;
      end else if (in_valid) begin
        case (r_state)
          IDLE: begin
            if (STRICT_START && (in_data != '0)) begin
              r_state     <= FAIL;
              r_mismatch  <= 1'b1;
              r_error     <= 1'b1;
              r_err_index <= '0;
            end else begin
              r_a          <= in_data;
              r_term_count <= CNT_W'(1);
              r_state      <= ONE;
            end
          end
          ONE: begin
            if (STRICT_START && (in_data != WIDTH'(1))) begin
              r_state     <= FAIL;
              r_mismatch  <= 1'b1;
              r_error     <= 1'b1;
              r_err_index <= CNT_W'(1);
            end else begin
              r_b          <= in_data;
              r_term_count <= CNT_W'(2);
              r_locked     <= 1'b1;
              r_state      <= TRACK;
            end
          end
          TRACK: begin
            if (in_data == w_expected) begin
              r_a          <= r_b;
              r_b          <= in_data;
              r_term_count <= w_count_inc;
              r_wrapped    <= r_wrapped | w_carry;
            end else begin
              r_state     <= FAIL;
              r_locked    <= 1'b0;
              r_mismatch  <= 1'b1;
              r_error     <= 1'b1;
              r_err_index <= r_term_count;
            end
          end
          default: ;  // FAIL holds everything until clear or reset
        endcase
      end
    end
  end

  assign term_count = r_term_count;
  assign locked     = r_locked;
  assign mismatch   = r_mismatch;
  assign error      = r_error;
  assign err_index  = r_err_index;
  assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_fib_checker.sv
// Directed bench for fib_checker: strict and free-seed instances, one task per scenario.
module tb_fib_checker;

  localparam int unsigned W = 16;
  localparam int unsigned C = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [C-1:0] term_count;
  logic         locked, mismatch, error, wrapped;
  logic [C-1:0] err_index;

  logic         ns_valid;
  logic [W-1:0] ns_data;
  logic [C-1:0] ns_term_count;
  logic         ns_locked, ns_mismatch, ns_error, ns_wrapped;
  logic [C-1:0] ns_err_index;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fib_checker #(.WIDTH(W), .CNT_W(C), .STRICT_START(1'b1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .term_count(term_count), .locked(locked), .mismatch(mismatch), .error(error),
    .err_index(err_index), .wrapped(wrapped)
  );

  fib_checker #(.WIDTH(W), .CNT_W(C), .STRICT_START(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(ns_valid), .in_data(ns_data),
    .term_count(ns_term_count), .locked(ns_locked), .mismatch(ns_mismatch), .error(ns_error),
    .err_index(ns_err_index), .wrapped(ns_wrapped)
  );

  // Present one sample (or idle) for one edge; returns 1 time unit after the edge.
  task automatic drive(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drive_ns(input logic v, input logic [W-1:0] d);
    ns_valid = v;
    ns_data  = d;
    @(posedge clk);
    #1;
    ns_valid = 1'b0;
    ns_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({term_count, locked, mismatch, error, err_index, wrapped} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got cnt=%0d lk=%b mm=%b er=%b idx=%0d wr=%b, want all 0",
               term_count, locked, mismatch, error, err_index, wrapped);
    end
  endtask

  task automatic test_seeded();
    logic [W-1:0] seq [6] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5};
    int bad_flags = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, seq[i]);
      if (mismatch || error || wrapped) bad_flags++;
      if (i == 0) begin
        n_checks++;
        if (locked !== 1'b0 || term_count !== 16'd1) begin
          n_errors++;
          $display("FAIL seeded_first: got lk=%b cnt=%0d, want lk=0 cnt=1", locked, term_count);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (locked !== 1'b1) begin
          n_errors++;
          $display("FAIL seeded_lock: got lk=%b, want 1 after 2nd sample", locked);
        end
      end
    end
    n_checks++;
    if (term_count !== 16'd6 || bad_flags != 0) begin
      n_errors++;
      $display("FAIL seeded_end: got cnt=%0d flag_hits=%0d, want cnt=6 flag_hits=0",
               term_count, bad_flags);
    end
  endtask

  task automatic test_mismatch();
    logic [W-1:0] seq [7] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd9};
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, seq[i]);
    n_checks++;
    if ({mismatch, error, locked} !== 3'b110 || err_index !== 16'd6 || term_count !== 16'd6) begin
      n_errors++;
      $display("FAIL mismatch_hit: got mm=%b er=%b lk=%b idx=%0d cnt=%0d, want 1 1 0 6 6",
               mismatch, error, locked, err_index, term_count);
    end
    drive(1'b1, 16'd8);
    n_checks++;
    if (mismatch !== 1'b0 || error !== 1'b1) begin
      n_errors++;
      $display("FAIL mismatch_pulse: got mm=%b er=%b, want mm=0 er=1", mismatch, error);
    end
    drive(1'b1, 16'd13);
    drive(1'b0, 16'd0);
    drive(1'b1, 16'd0);
    n_checks++;
    if ({mismatch, error, locked, wrapped} !== 4'b0100 || err_index !== 16'd6 ||
        term_count !== 16'd6) begin
      n_errors++;
      $display("FAIL mismatch_frozen: got mm=%b er=%b lk=%b wr=%b idx=%0d cnt=%0d, want 0 1 0 0 6 6",
               mismatch, error, locked, wrapped, err_index, term_count);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] seq [26] = '{
      16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34,
      16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987, 16'd1597,
      16'd2584, 16'd4181, 16'd6765, 16'd10946, 16'd17711, 16'd28657, 16'd46368, 16'd9489};
    do_reset();
    for (int i = 0; i < 26; i++) begin
      drive(1'b1, seq[i]);
      if (i == 24) begin
        n_checks++;
        if (wrapped !== 1'b0) begin
          n_errors++;
          $display("FAIL overflow_early: got wr=%b at index 24, want 0", wrapped);
        end
      end
    end
    n_checks++;
    if (wrapped !== 1'b1 || error !== 1'b0 || term_count !== 16'd26 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_end: got wr=%b er=%b cnt=%0d lk=%b, want 1 0 26 1",
               wrapped, error, term_count, locked);
    end
  endtask

  task automatic test_seed_rules();
    do_reset();
    drive(1'b1, 16'd5);
    n_checks++;
    if ({mismatch, error} !== 2'b11 || err_index !== 16'd0 || term_count !== 16'd0) begin
      n_errors++;
      $display("FAIL strict_seed0: got mm=%b er=%b idx=%0d cnt=%0d, want 1 1 0 0",
               mismatch, error, err_index, term_count);
    end
    do_reset();
    drive(1'b1, 16'd0);
    drive(1'b1, 16'd2);
    n_checks++;
    if (error !== 1'b1 || err_index !== 16'd1 || term_count !== 16'd1) begin
      n_errors++;
      $display("FAIL strict_seed1: got er=%b idx=%0d cnt=%0d, want 1 1 1",
               error, err_index, term_count);
    end
    drive_ns(1'b1, 16'd5);
    drive_ns(1'b1, 16'd8);
    drive_ns(1'b1, 16'd13);
    drive_ns(1'b1, 16'd21);
    n_checks++;
    if (ns_term_count !== 16'd4 || ns_error !== 1'b0 || ns_locked !== 1'b1) begin
      n_errors++;
      $display("FAIL free_seed: got cnt=%0d er=%b lk=%b, want 4 0 1",
               ns_term_count, ns_error, ns_locked);
    end
  endtask

  task automatic test_clear();
    do_reset();
    drive(1'b1, 16'd0);
    drive(1'b1, 16'd1);
    drive(1'b1, 16'd1);
    clear = 1'b1;
    drive(1'b1, 16'd2);
    clear = 1'b0;
    n_checks++;
    if ({term_count, locked, mismatch, error, err_index, wrapped} !== '0) begin
      n_errors++;
      $display("FAIL clear_track: got cnt=%0d lk=%b mm=%b er=%b idx=%0d wr=%b, want all 0",
               term_count, locked, mismatch, error, err_index, wrapped);
    end
    drive(1'b1, 16'd0);
    drive(1'b1, 16'd1);
    n_checks++;
    if (term_count !== 16'd2 || locked !== 1'b1 || error !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_restart: got cnt=%0d lk=%b er=%b, want 2 1 0", term_count, locked, error);
    end
    drive(1'b1, 16'd7);
    clear = 1'b1;
    drive(1'b0, 16'd0);
    clear = 1'b0;
    n_checks++;
    if ({term_count, locked, mismatch, error, err_index, wrapped} !== '0) begin
      n_errors++;
      $display("FAIL clear_fail: got cnt=%0d lk=%b mm=%b er=%b idx=%0d wr=%b, want all 0",
               term_count, locked, mismatch, error, err_index, wrapped);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 16'd0);
    drive(1'b1, 16'd1);
    drive(1'b1, 16'd1);
    drive(1'b1, 16'd2);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({term_count, locked, mismatch, error, err_index, wrapped} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got cnt=%0d lk=%b er=%b before next edge, want all 0",
               term_count, locked, error);
    end
    #1;
    reset = 1'b0;
    drive(1'b1, 16'd0);
    n_checks++;
    if (term_count !== 16'd1 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL async_restart: got cnt=%0d lk=%b, want 1 0", term_count, locked);
    end
  endtask

  // Behavioural stand-in for the generator: each enabled cycle emits done with the next term.
  task automatic test_generator();
    logic [W-1:0] ga = 16'd0;
    logic [W-1:0] gb = 16'd1;
    logic [W-1:0] gn;
    int pulses = 0;
    int mm_seen = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, ga);
        gn = ga + gb;
        ga = gb;
        gb = gn;
        pulses++;
      end else begin
        drive(1'b0, 16'd0);
      end
      if (mismatch || error) mm_seen++;
    end
    n_checks++;
    if (mm_seen != 0 || term_count !== C'(pulses)) begin
      n_errors++;
      $display("FAIL generator: got cnt=%0d mismatch_cycles=%0d, want cnt=%0d mismatch_cycles=0",
               term_count, mm_seen, pulses);
    end
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ns_valid = 1'b0;
    ns_data  = '0;
    test_reset();
    test_seeded();
    test_mismatch();
    test_overflow();
    test_seed_rules();
    test_clear();
    test_async_reset();
    test_generator();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fib_checker.md
# fib_checker

Stream checker for the Fibonacci generator's output. It samples a valid-qualified data stream and confirms that every sample is the next term of a Fibonacci sequence under modulo-2^WIDTH arithmetic. It reports lock, term count, the first mismatch and sum overflow. It sits downstream of the generator: the generator's done strobe drives `in_valid` and its `fib_out` drives `in_data`, with no glue logic. It is used in self-checking benches and as an on-chip sequence monitor.

## Interface
- `WIDTH`, 16, data width of the monitored stream.
- `CNT_W`, 16, width of the term counter and the error index.
- `STRICT_START`, 1:
  - 1: the first two samples must be 0 then 1.
  - 0: any two seed values are accepted.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous restart. It has priority over `in_valid`.
- `in_valid` in 1: sample strobe. `in_data` is sampled on the edge where this is high.
- `in_data` in WIDTH: sample value.
- `term_count` out CNT_W: number of samples accepted so far. Saturates at all-ones.
- `locked` out 1: high while in TRACK.
- `mismatch` out 1: one-cycle pulse on the first bad sample.
- `error` out 1: sticky, set together with `mismatch`.
- `err_index` out CNT_W: 0-based index of the failing sample.
- `wrapped` out 1: sticky, set when an accepted term required a carry out of WIDTH bits.

## Operation
- Internal state:
  - `a`, `b`: the last two accepted terms, WIDTH bits each.
  - FSM with states IDLE, ONE, TRACK, FAIL.
- IDLE, on `in_valid`:
  - If STRICT_START=1 and `in_data` != 0: go to FAIL with `err_index` = 0.
  - Otherwise: `a` <= `in_data`, `term_count` <= 1, go to ONE.
- ONE, on `in_valid`:
  - If STRICT_START=1 and `in_data` != 1: go to FAIL with `err_index` = 1.
  - Otherwise: `b` <= `in_data`, `term_count` <= 2, go to TRACK.
- TRACK, on `in_valid`:
  - Compute `sum` = `a` + `b` at WIDTH+1 bits. The expected value is `sum[WIDTH-1:0]`.
  - Equal: `a` <= `b`, `b` <= `in_data`, `term_count`++, and `wrapped` |= `sum[WIDTH]`.
  - Not equal: go to FAIL with `err_index` = `term_count`.
- FAIL:
  - `in_valid` is ignored.
  - `term_count`, `a` and `b` are frozen.
  - Exit only through `clear` or `reset`.
- Any state, with `in_valid` low: no change.
- `mismatch` pulses in the cycle the FSM enters FAIL, and only then.
- `clear`: returns to IDLE and zeroes `a`, `b`, `term_count`, `err_index`, `error`, `wrapped` and `mismatch`. A sample presented in the same cycle is dropped.
- Reset values: state IDLE, `a` = `b` = 0, and all outputs 0.
- Reset asserted mid-operation takes effect immediately and returns everything to these values.

## Timing
- All outputs are registered. Each output reflects a sample one cycle after the edge on which it was captured.
- Latency from `in_valid` to `mismatch` or `term_count` update: 1 cycle.
- `locked` rises on the edge that accepts the second sample.
- `locked` falls on the edge that enters FAIL, or on `clear` or `reset`.
- Back-to-back `in_valid` is supported every cycle, with no backpressure. Gaps of any length are allowed.
- `term_count` saturation: stays at 2^CNT_W-1. The comparison continues after saturation.
- `err_index` holds its value until `clear` or `reset`.

## Structure
- Shared package `fib_pkg`:
  - FSM state enum `fib_chk_state_t` (IDLE, ONE, TRACK, FAIL).
  - Default width constant `FIB_WIDTH` = 16, also used by the generator.
- Sub-module `fib_step`: combinational WIDTH+1-bit adder producing the next expected term and its carry. Reusable by a future generator refactor.
- All remaining logic lives in a single module.

## Test plan
- Seeded sequence:
  - Stimulus: reset, then feed 0,1,1,2,3,5 on consecutive cycles.
  - Response: `locked` goes to 1 after the 2nd sample, `term_count` reaches 6, `mismatch`, `error` and `wrapped` stay 0.
- Single mismatch:
  - Stimulus: feed 0,1,1,2,3,5,9.
  - Response: `mismatch` pulses once, `error` = 1, `err_index` = 6, `locked` = 0, `term_count` = 6.
  - Follow-up: further samples leave every output unchanged.
- Overflow:
  - Stimulus: feed 26 terms ending in 28657, 46368, 9489.
  - Response: all 26 are accepted, `wrapped` = 1 after index 25, `error` = 0, `term_count` = 26.
- Seed rules:
  - STRICT_START=1, first sample 5: `error` = 1 and `err_index` = 0.
  - STRICT_START=0, samples 5,8,13,21: all accepted, `term_count` = 4.
- Clear and reset:
  - `clear` together with `in_valid` in TRACK: the sample is dropped, state returns to IDLE, all outputs are 0.
  - Async `reset` pulse between clock edges mid-TRACK: outputs are 0 before the next edge.
- Generator hookup:
  - Stimulus: the generator's done and `fib_out` drive `in_valid` and `in_data`, with enable toggled randomly for 200 cycles.
  - Response: no mismatch, and `term_count` equals the number of done pulses.
